// File: rtl/data_sram_ctrl_pkg.sv
// Shared definitions for the data-side SRAM controller: FSM states, SRAM data width
// and the byte-lane convention shared with the MEM stage.
package data_sram_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StDone   = 2'd2
    } sram_state_e;

    localparam int unsigned SRAM_DW = 32;
    localparam int unsigned SRAM_BW = SRAM_DW / 8;
    localparam int unsigned CNT_W   = 4;

    // Byte lane i covers data[8i+7:8i]; sel[3] is the lowest byte address (big-endian lanes).
    localparam logic [SRAM_BW-1:0] LANES_NONE = '0;

endpackage

// File: rtl/data_sram_ctrl.sv
// Data-memory controller for an asynchronous 32-bit SRAM. Holds the core pipeline while a
// fixed-length access strobe runs, then releases it for one hold cycle before going idle.
module data_sram_ctrl
    import data_sram_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned SRAM_AW     = 20
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mem_ce_i,
    input  logic                mem_we_i,
    input  logic [31:0]         mem_addr_i,
    input  logic [SRAM_BW-1:0]  mem_sel_i,
    input  logic [SRAM_DW-1:0]  mem_data_i,
    output logic [SRAM_DW-1:0]  mem_data_o,
    output logic                stall_o,
    output logic [SRAM_AW-1:0]  sram_addr_o,
    output logic                sram_ce_n_o,
    output logic                sram_oe_n_o,
    output logic                sram_we_n_o,
    output logic [SRAM_BW-1:0]  sram_be_n_o,
    output logic [SRAM_DW-1:0]  sram_dq_o,
    output logic                sram_dq_oe_o,
    input  logic [SRAM_DW-1:0]  sram_dq_i
);

    sram_state_e          state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [SRAM_AW-1:0]   addr_q, addr_d;
    logic                 we_q, we_d;
    logic [SRAM_BW-1:0]   sel_q, sel_d;
    logic [SRAM_DW-1:0]   wdata_q, wdata_d;
    logic [SRAM_DW-1:0]   rdata_q, rdata_d;
    logic                 dq_oe_q, dq_oe_d;
    logic                 stall;

    // Word address only: byte offset and bits beyond the SRAM are not used.
    logic unused_addr;
    assign unused_addr = ^{mem_addr_i[31:SRAM_AW+2], mem_addr_i[1:0]};

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        we_d         = we_q;
        sel_d        = sel_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        dq_oe_d      = 1'b0;
        stall        = 1'b0;
        sram_ce_n_o  = 1'b1;
        sram_oe_n_o  = 1'b1;
        sram_we_n_o  = 1'b1;
        sram_dq_oe_o = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (mem_ce_i) begin
                    stall = 1'b1;
                    if (mem_sel_i != LANES_NONE) begin
                        addr_d  = mem_addr_i[SRAM_AW+1:2];
                        we_d    = mem_we_i;
                        sel_d   = mem_sel_i;
                        wdata_d = mem_data_i;
                        cnt_d   = CNT_W'(WAIT_CYCLES);
                        state_d = StAccess;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StAccess: begin
                stall        = 1'b1;
                sram_ce_n_o  = 1'b0;
                sram_oe_n_o  = we_q;
                sram_we_n_o  = ~we_q;
                sram_dq_oe_o = we_q;
                dq_oe_d      = we_q;
                cnt_d        = cnt_q - 1'b1;
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = StDone;
                    if (!we_q) begin
                        rdata_d = sram_dq_i;
                    end
                end
            end
            StDone: begin
                // Keep driving the bus for one cycle so write data holds past we_n rising.
                sram_dq_oe_o = dq_oe_q;
                state_d      = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            dq_oe_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            dq_oe_q <= dq_oe_d;
        end
    end

    assign stall_o     = stall & ~rst;
    assign mem_data_o  = rdata_q;
    assign sram_addr_o = addr_q;
    assign sram_be_n_o = ~sel_q;
    assign sram_dq_o   = wdata_q;

endmodule

// File: tb/tb_data_sram_ctrl.sv
// Directed bench for data_sram_ctrl: one instance with WAIT_CYCLES=1 and one with 3,
// sharing all inputs except the request valid.
module tb_data_sram_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce1 = 1'b0;
    logic        ce3 = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [3:0]  sel = '0;
    logic [31:0] wdata = '0;
    logic [31:0] dq_i = '0;

    logic [31:0] mdata1, dq_o1, mdata3, dq_o3;
    logic [19:0] saddr1, saddr3;
    logic [3:0]  be_n1, be_n3;
    logic        stall1, ce_n1, oe_n1, we_n1, dq_oe1;
    logic        stall3, ce_n3, oe_n3, we_n3, dq_oe3;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    data_sram_ctrl #(.WAIT_CYCLES(1), .SRAM_AW(20)) u_dut1 (
        .clk(clk), .rst(rst), .mem_ce_i(ce1), .mem_we_i(we), .mem_addr_i(addr),
        .mem_sel_i(sel), .mem_data_i(wdata), .mem_data_o(mdata1), .stall_o(stall1),
        .sram_addr_o(saddr1), .sram_ce_n_o(ce_n1), .sram_oe_n_o(oe_n1), .sram_we_n_o(we_n1),
        .sram_be_n_o(be_n1), .sram_dq_o(dq_o1), .sram_dq_oe_o(dq_oe1), .sram_dq_i(dq_i)
    );

    data_sram_ctrl #(.WAIT_CYCLES(3), .SRAM_AW(20)) u_dut3 (
        .clk(clk), .rst(rst), .mem_ce_i(ce3), .mem_we_i(we), .mem_addr_i(addr),
        .mem_sel_i(sel), .mem_data_i(wdata), .mem_data_o(mdata3), .stall_o(stall3),
        .sram_addr_o(saddr3), .sram_ce_n_o(ce_n3), .sram_oe_n_o(oe_n3), .sram_we_n_o(we_n3),
        .sram_be_n_o(be_n3), .sram_dq_o(dq_o3), .sram_dq_oe_o(dq_oe3), .sram_dq_i(dq_i)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; ce1 = 1'b1; ce3 = 1'b1; sel = 4'hF; we = 1'b0;
        step();
        #1;
        n_checks++; if (stall1 !== 1'b0) begin n_fail++; $display("FAIL rst_stall1: got %b expected 0", stall1); end
        n_checks++; if (stall3 !== 1'b0) begin n_fail++; $display("FAIL rst_stall3: got %b expected 0", stall3); end
        n_checks++; if (mdata1 !== 32'h0) begin n_fail++; $display("FAIL rst_mdata: got %h expected 0", mdata1); end
        n_checks++; if (saddr1 !== 20'h0) begin n_fail++; $display("FAIL rst_addr: got %h expected 0", saddr1); end
        n_checks++; if (be_n1 !== 4'hF) begin n_fail++; $display("FAIL rst_be_n: got %b expected 1111", be_n1); end
        n_checks++; if (dq_o1 !== 32'h0) begin n_fail++; $display("FAIL rst_dq_o: got %h expected 0", dq_o1); end
        n_checks++; if ({ce_n1, oe_n1, we_n1, dq_oe1} !== 4'b1110) begin
            n_fail++; $display("FAIL rst_strobes: got %b expected 1110", {ce_n1, oe_n1, we_n1, dq_oe1});
        end
        ce1 = 1'b0; ce3 = 1'b0;
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_read_word();
        addr = 32'h10; sel = 4'hF; we = 1'b0; dq_i = 32'hDEADBEEF; ce1 = 1'b1;
        #1;
        n_checks++; if (stall1 !== 1'b1) begin n_fail++; $display("FAIL rd_idle_stall: got %b expected 1", stall1); end
        n_checks++; if (ce_n1 !== 1'b1) begin n_fail++; $display("FAIL rd_idle_ce_n: got %b expected 1", ce_n1); end
        step();
        ce1 = 1'b0;
        #1;
        n_checks++; if ({ce_n1, oe_n1, we_n1, dq_oe1, stall1} !== 5'b00101) begin
            n_fail++; $display("FAIL rd_access_ctl: got %b expected 00101", {ce_n1, oe_n1, we_n1, dq_oe1, stall1});
        end
        n_checks++; if (saddr1 !== 20'h00004) begin n_fail++; $display("FAIL rd_addr: got %h expected 00004", saddr1); end
        n_checks++; if (be_n1 !== 4'h0) begin n_fail++; $display("FAIL rd_be_n: got %b expected 0000", be_n1); end
        step();
        #1;
        n_checks++; if ({ce_n1, oe_n1, stall1} !== 3'b110) begin
            n_fail++; $display("FAIL rd_done_ctl: got %b expected 110", {ce_n1, oe_n1, stall1});
        end
        n_checks++; if (mdata1 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_data: got %h expected deadbeef", mdata1); end
        dq_i = 32'h0;
        step();
        #1;
        n_checks++; if ({ce_n1, oe_n1, we_n1, dq_oe1, stall1} !== 5'b11100) begin
            n_fail++; $display("FAIL rd_idle_after: got %b expected 11100", {ce_n1, oe_n1, we_n1, dq_oe1, stall1});
        end
        n_checks++; if (mdata1 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_data_hold: got %h expected deadbeef", mdata1); end
    endtask

    task automatic test_byte_store();
        addr = 32'h7; sel = 4'b0001; wdata = 32'h5A5A5A5A; we = 1'b1; ce1 = 1'b1;
        #1;
        n_checks++; if (stall1 !== 1'b1) begin n_fail++; $display("FAIL st_idle_stall: got %b expected 1", stall1); end
        step();
        ce1 = 1'b0; wdata = 32'h0; addr = 32'h0; sel = 4'hF;
        #1;
        n_checks++; if ({ce_n1, oe_n1, we_n1, dq_oe1} !== 4'b0101) begin
            n_fail++; $display("FAIL st_access_ctl: got %b expected 0101", {ce_n1, oe_n1, we_n1, dq_oe1});
        end
        n_checks++; if (be_n1 !== 4'b1110) begin n_fail++; $display("FAIL st_be_n: got %b expected 1110", be_n1); end
        n_checks++; if (dq_o1 !== 32'h5A5A5A5A) begin n_fail++; $display("FAIL st_dq_o: got %h expected 5a5a5a5a", dq_o1); end
        n_checks++; if (saddr1 !== 20'h1) begin n_fail++; $display("FAIL st_addr: got %h expected 00001", saddr1); end
        step();
        #1;
        n_checks++; if ({ce_n1, we_n1, dq_oe1, stall1} !== 4'b1110) begin
            n_fail++; $display("FAIL st_done_ctl: got %b expected 1110", {ce_n1, we_n1, dq_oe1, stall1});
        end
        n_checks++; if (dq_o1 !== 32'h5A5A5A5A || saddr1 !== 20'h1) begin
            n_fail++; $display("FAIL st_done_hold: got %h/%h expected 5a5a5a5a/00001", dq_o1, saddr1);
        end
        step();
        #1;
        n_checks++; if (dq_oe1 !== 1'b0) begin n_fail++; $display("FAIL st_idle_dq_oe: got %b expected 0", dq_oe1); end
        n_checks++; if (mdata1 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL st_mdata: got %h expected deadbeef", mdata1); end
    endtask

    task automatic test_noop();
        sel = 4'b0000; we = 1'b0; addr = 32'h40; dq_i = 32'h13572468; ce1 = 1'b1;
        #1;
        n_checks++; if (stall1 !== 1'b1) begin n_fail++; $display("FAIL noop_stall: got %b expected 1", stall1); end
        step();
        ce1 = 1'b0;
        #1;
        n_checks++; if ({ce_n1, oe_n1, we_n1, stall1} !== 4'b1110) begin
            n_fail++; $display("FAIL noop_done_ctl: got %b expected 1110", {ce_n1, oe_n1, we_n1, stall1});
        end
        n_checks++; if (mdata1 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL noop_mdata: got %h expected deadbeef", mdata1); end
        step();
        #1;
        n_checks++; if (mdata1 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL noop_mdata2: got %h expected deadbeef", mdata1); end
    endtask

    task automatic test_back_to_back();
        logic [4:0] exp_stall;
        logic [4:0] exp_ce_n;
        exp_stall = 5'b11011;
        exp_ce_n  = 5'b01101;
        addr = 32'h100; sel = 4'hF; we = 1'b0; dq_i = 32'h11223344; ce1 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++; if (stall1 !== exp_stall[i]) begin
                n_fail++; $display("FAIL b2b_stall[%0d]: got %b expected %b", i, stall1, exp_stall[i]);
            end
            n_checks++; if (ce_n1 !== exp_ce_n[i]) begin
                n_fail++; $display("FAIL b2b_ce_n[%0d]: got %b expected %b", i, ce_n1, exp_ce_n[i]);
            end
            step();
        end
        ce1 = 1'b0;
        #1;
        n_checks++; if (mdata1 !== 32'h11223344) begin n_fail++; $display("FAIL b2b_mdata: got %h expected 11223344", mdata1); end
        step();
    endtask

    task automatic test_halfword_wait3();
        int stall_cnt = 0;
        int oe_cnt = 0;
        logic be_bad = 1'b0;
        addr = 32'h2; sel = 4'b0011; we = 1'b0; ce3 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            dq_i = (i == 3) ? 32'h0000CAFE : 32'hBAD0BAD0;
            #1;
            if (stall3) stall_cnt++;
            if (!oe_n3) begin
                oe_cnt++;
                if (be_n3 !== 4'b1100 || saddr3 !== 20'h0) be_bad = 1'b1;
            end
            step();
            if (i == 0) ce3 = 1'b0;
        end
        n_checks++; if (stall_cnt != 4) begin n_fail++; $display("FAIL hw_stall_cycles: got %0d expected 4", stall_cnt); end
        n_checks++; if (oe_cnt != 3) begin n_fail++; $display("FAIL hw_oe_cycles: got %0d expected 3", oe_cnt); end
        n_checks++; if (be_bad !== 1'b0) begin n_fail++; $display("FAIL hw_be_addr: got bad=%b expected 0", be_bad); end
        n_checks++; if (mdata3 !== 32'h0000CAFE) begin n_fail++; $display("FAIL hw_mdata: got %h expected 0000cafe", mdata3); end
    endtask

    task automatic test_ce_drop_write();
        int stall_cnt = 0;
        int we_cnt = 0;
        logic bus_bad = 1'b0;
        addr = 32'h20; sel = 4'hF; we = 1'b1; wdata = 32'h12345678; ce3 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i >= 1) begin
                wdata = 32'hFFFFFFFF; addr = 32'h0; sel = 4'h0; we = 1'b0;
            end
            #1;
            if (stall3) stall_cnt++;
            if (!we_n3) begin
                we_cnt++;
                if (dq_o3 !== 32'h12345678 || saddr3 !== 20'h8 || dq_oe3 !== 1'b1) bus_bad = 1'b1;
            end
            step();
            if (i == 0) ce3 = 1'b0;
        end
        n_checks++; if (we_cnt != 3) begin n_fail++; $display("FAIL cd_we_cycles: got %0d expected 3", we_cnt); end
        n_checks++; if (stall_cnt != 4) begin n_fail++; $display("FAIL cd_stall_cycles: got %0d expected 4", stall_cnt); end
        n_checks++; if (bus_bad !== 1'b0) begin n_fail++; $display("FAIL cd_bus: got bad=%b expected 0", bus_bad); end
        n_checks++; if (mdata3 !== 32'h0000CAFE) begin n_fail++; $display("FAIL cd_mdata: got %h expected 0000cafe", mdata3); end
    endtask

    task automatic test_rst_mid_access();
        logic late_bad = 1'b0;
        addr = 32'h40; sel = 4'hF; we = 1'b0; dq_i = 32'hA5A5A5A5; ce3 = 1'b1;
        step();
        ce3 = 1'b0;
        #1;
        n_checks++; if (ce_n3 !== 1'b0) begin n_fail++; $display("FAIL rm_access1: got ce_n=%b expected 0", ce_n3); end
        step();
        rst = 1'b1;
        #1;
        n_checks++; if (stall3 !== 1'b0) begin n_fail++; $display("FAIL rm_stall_in_rst: got %b expected 0", stall3); end
        step();
        rst = 1'b0;
        #1;
        n_checks++; if ({ce_n3, oe_n3, we_n3, dq_oe3, stall3} !== 5'b11100) begin
            n_fail++; $display("FAIL rm_after_rst: got %b expected 11100", {ce_n3, oe_n3, we_n3, dq_oe3, stall3});
        end
        n_checks++; if (mdata3 !== 32'h0) begin n_fail++; $display("FAIL rm_mdata: got %h expected 0", mdata3); end
        for (int i = 0; i < 4; i++) begin
            step();
            #1;
            if (oe_n3 !== 1'b1 || ce_n3 !== 1'b1 || mdata3 !== 32'h0) late_bad = 1'b1;
        end
        n_checks++; if (late_bad !== 1'b0) begin n_fail++; $display("FAIL rm_no_done: got bad=%b expected 0", late_bad); end
    endtask

    initial begin
        test_reset();
        test_read_word();
        step();
        test_byte_store();
        step();
        test_noop();
        test_back_to_back();
        step();
        test_halfword_wait3();
        test_ce_drop_write();
        test_rst_mid_access();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/data_sram_ctrl.md
DATA_SRAM_CTRL -- requirements
Module: data_sram_ctrl

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 1, SRAM access-strobe length in cycles, legal range 1..15.
REQ-002 SHALL have parameter SRAM_AW, default 20, SRAM word-address width.
REQ-003 SHALL have port clk, input, 1, rising-edge clock.
REQ-004 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port mem_ce_i, input, 1, core data request valid.
REQ-006 SHALL have port mem_we_i, input, 1, 1 means write, 0 means read.
REQ-007 SHALL have port mem_addr_i, input, 32, byte address.
REQ-008 SHALL have port mem_sel_i, input, 4, byte-lane enables; sel[3] = data[31:24] (addr[1:0]=00), sel[0] = data[7:0] (addr[1:0]=11).
REQ-009 SHALL have port mem_data_i, input, 32, write data, already lane-replicated by the core.
REQ-010 SHALL have port mem_data_o, output, 32, read data returned to the core.
REQ-011 SHALL have port stall_o, output, 1, pipeline hold request.
REQ-012 SHALL have ports sram_addr_o (output, SRAM_AW), sram_ce_n_o, sram_oe_n_o, sram_we_n_o (output, 1 each, active-low), sram_be_n_o (output, 4, active-low, bit i = dq[8i+7:8i]).
REQ-013 SHALL have ports sram_dq_o (output, 32), sram_dq_oe_o (output, 1, drive enable) and sram_dq_i (input, 32); the tristate lives at top level.

Function
REQ-014 SHALL implement FSM states IDLE, ACCESS, DONE.
REQ-015 IDLE: on mem_ce_i=1 with mem_sel_i!=0, SHALL latch addr[SRAM_AW+1:2], we, sel, wdata; load wait counter with WAIT_CYCLES; go to ACCESS.
REQ-016 IDLE: on mem_ce_i=1 with mem_sel_i=0000, SHALL go to DONE without any SRAM strobe (no-op completion).
REQ-017 ACCESS: sram_ce_n_o=0; sram_be_n_o=~latched sel; counter decrements each cycle; go to DONE when the counter reaches 1.
REQ-018 ACCESS read: sram_oe_n_o=0, sram_dq_oe_o=0; read data register SHALL capture sram_dq_i on the final ACCESS cycle.
REQ-019 ACCESS write: sram_we_n_o=0, sram_dq_oe_o=1, sram_dq_o=latched wdata.
REQ-020 DONE (hold cycle): sram_addr_o and sram_dq_o unchanged, sram_we_n_o=1, sram_oe_n_o=1, sram_ce_n_o=1, sram_dq_oe_o held at its ACCESS value; next state IDLE unconditionally.
REQ-021 stall_o SHALL equal (state==IDLE && mem_ce_i && first-cycle acceptance) || state==ACCESS; stall_o=0 in DONE.
REQ-022 Latency: request-to-stall release SHALL be WAIT_CYCLES+1 cycles; the core advances on the DONE edge; total occupancy WAIT_CYCLES+2 cycles.
REQ-023 mem_data_o SHALL be the read data register (full 32-bit word; the core performs lane extraction) and SHALL hold until the next read capture; writes SHALL NOT alter it.
REQ-024 mem_ce_i dropping during ACCESS SHALL NOT abort the transaction; the access completes and stall_o stays 1 until DONE.
REQ-025 Input changes during ACCESS/DONE SHALL be ignored; only the values latched in IDLE are used.
REQ-026 Back-to-back requests: a new request SHALL be accepted only in IDLE, i.e., one idle cycle minimum after each DONE.
REQ-027 In IDLE with mem_ce_i=0: all SRAM strobes inactive, sram_dq_oe_o=0.

Reset
REQ-028 rst=1 at a clock edge SHALL force state IDLE, counter 0, and read data register 0, so mem_data_o=0; latched addr/sel/wdata SHALL be 0, giving sram_addr_o=0, sram_be_n_o=1111 and sram_dq_o=0; sram_ce_n_o, sram_oe_n_o and sram_we_n_o SHALL be 1; sram_dq_oe_o=0.
REQ-029 rst asserted mid-ACCESS SHALL abandon the transaction; strobes SHALL be inactive from the next cycle; no DONE SHALL be generated.
REQ-030 stall_o SHALL be 0 while rst=1.

Structure
REQ-031 State encoding and SRAM width constants SHALL live in the shared defines/package; byte-lane convention constants are shared with the MEM stage.
REQ-032 SHALL be a single module with no sub-module; the wait counter is 4 bits.

Verification
REQ-033 Read word, WAIT_CYCLES=1: ce=1, we=0, addr=0x0000_0010, sel=1111, SRAM returns 0xDEADBEEF -> sram_addr_o=0x00004, stall_o high 2 cycles, mem_data_o=0xDEADBEEF.
REQ-034 Byte store: addr=0x0000_0007, sel=0001, data=0x5A5A5A5A -> sram_be_n_o=1110, we_n low 1 cycle, dq_oe_o=1 through DONE.
REQ-035 WAIT_CYCLES=3 halfword load at addr 0x2: sel=0011 -> oe_n low 3 cycles; stall_o high 4 cycles.
REQ-036 sel=0000 with ce=1 -> no SRAM strobe; stall_o high 1 cycle; mem_data_o unchanged.
REQ-037 rst pulsed on the 2nd ACCESS cycle (WAIT_CYCLES=3) -> next cycle all strobes high, stall_o=0, mem_data_o=0.
REQ-038 ce dropped after 1 cycle of a write -> write still completes with full WAIT_CYCLES strobe.
